store_block: RTL and testbench

- Write-side counterpart of load_block.
- Takes a block of up to MAX_WORDS signed words produced by a compute layer and writes it to DMA memory, one word per clock, at consecutive addresses from a base address.
- Signals completion with a done level, so that convolution/pooling layers can hand off result write-back the same way they request input loads.

---
 rtl/dcnn_pkg.sv | 25 ++
 rtl/store_block.sv | 113 +++++++++++
 tb/tb_store_block.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dcnn_pkg.sv
// Shared DCNN constants, word type and store FSM states.
// Used by load_block, store_block, the DMA and the layers.
package dcnn_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int MAX_WORDS = 1024;
  localparam int IDX_W     = $clog2(MAX_WORDS);

  typedef logic signed [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0]        addr_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } store_state_t;

  function automatic addr_t clamp_size(input addr_t s);
    if (s > addr_t'(MAX_WORDS))
      return addr_t'(MAX_WORDS);
    return s;
  endfunction

endpackage

// File: rtl/store_block.sv
// Writes a block of up to MAX_WORDS words to DMA memory,
// one word per clock, then holds done until enable drops.
module store_block
  import dcnn_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  enable,
  input  addr_t size,
  input  addr_t address,
  input  word_t in [0:MAX_WORDS-1],
  output addr_t dmaAddr,
  output word_t dmaData,
  output logic  dmaWrite,
  output logic  done
);

  store_state_t state_q, state_d;
  addr_t        idx_q, idx_d;
  addr_t        base_q, base_d;
  addr_t        count_q, count_d;
  addr_t        addr_q, addr_d;
  word_t        data_q, data_d;
  logic         wr_q, wr_d;
  logic         done_q, done_d;
  addr_t        start_cnt;

  assign start_cnt = clamp_size(size);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    done_d  = done_q;
    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (enable) begin
          base_d  = address;
          count_d = start_cnt;
          if (start_cnt != '0) begin
            state_d = WRITE;
            addr_d  = address;
            data_d  = in[0];
            wr_d    = 1'b1;
            idx_d   = addr_t'(1);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      WRITE: begin
        if (!enable) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (idx_q < count_q) begin
          addr_d = base_q + idx_q;
          data_d = in[idx_q[IDX_W-1:0]];
          wr_d   = 1'b1;
          idx_d  = idx_q + addr_t'(1);
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        if (!enable) begin
          state_d = IDLE;
          done_d  = 1'b0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
    end
  end

  assign dmaAddr  = addr_q;
  assign dmaData  = data_q;
  assign dmaWrite = wr_q;
  assign done     = done_q;

endmodule

// File: tb/tb_store_block.sv
// Directed and randomized checks of store_block against a
// write-list model and a DMA memory image.
module tb_store_block;
  import dcnn_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  logic  enable;
  addr_t size;
  addr_t address;
  word_t din [0:MAX_WORDS-1];
  addr_t dmaAddr;
  word_t dmaData;
  logic  dmaWrite;
  logic  done;

  int checks = 0;
  int errors = 0;
  logic [15:0] mem [int];

  store_block dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .size     (size),
    .address  (address),
    .in       (din),
    .dmaAddr  (dmaAddr),
    .dmaData  (dmaData),
    .dmaWrite (dmaWrite),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (dmaWrite) mem[int'(dmaAddr)] = dmaData;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int a);
    if (mem.exists(a)) return {16'h0, mem[a]};
    return 32'h1_0000;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < MAX_WORDS; i++)
      din[i] = word_t'($urandom);
  endtask

  task automatic run_block(input int sz,
                           input logic [15:0] a,
                           input string tag);
    int cnt, n, m;
    logic [15:0] qa[$];
    logic [15:0] qd[$];
    logic [15:0] ea;
    cnt = (sz > MAX_WORDS) ? MAX_WORDS : sz;
    mem.delete();
    size    = addr_t'(sz);
    address = a;
    enable  = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        size    = addr_t'($urandom);
        address = addr_t'($urandom);
      end
      if (dmaWrite) begin
        qa.push_back(dmaAddr);
        qd.push_back(dmaData);
      end
    end while (!done && n < cnt + 8);
    chk({tag, " done"}, {31'h0, done}, 32'h1);
    chk({tag, " latency"}, n, cnt + 1);
    chk({tag, " nwrites"}, qa.size(), cnt);
    m = (qa.size() < cnt) ? qa.size() : cnt;
    for (int i = 0; i < m; i++) begin
      ea = a + 16'(i);
      chk({tag, " addr"}, {16'h0, qa[i]}, {16'h0, ea});
      chk({tag, " data"}, {16'h0, qd[i]}, {16'h0, din[i]});
      chk({tag, " mem"}, rd(int'(ea)), {16'h0, din[i]});
    end
    @(posedge clk); #1;
    chk({tag, " hold done"}, {31'h0, done}, 32'h1);
    chk({tag, " hold wr"}, {31'h0, dmaWrite}, 32'h0);
    enable = 1'b0;
    @(posedge clk); #1;
    chk({tag, " clr done"}, {31'h0, done}, 32'h0);
    chk({tag, " clr wr"}, {31'h0, dmaWrite}, 32'h0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " addr0"}, {16'h0, dmaAddr}, 32'h0);
    chk({tag, " data0"}, {16'h0, dmaData}, 32'h0);
    chk({tag, " wr0"}, {31'h0, dmaWrite}, 32'h0);
    chk({tag, " done0"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    size    = '0;
    address = '0;
    fill_rand();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    din[0] = 16'sd10;
    din[1] = -16'sd20;
    din[2] = 16'sd30;
    din[3] = -16'sd40;
    run_block(4, 16'd100, "b4");

    run_block(0, 16'd500, "b0");
    chk("b0 nowrite", rd(500), 32'h1_0000);

    din[0] = 16'sd1;
    din[1] = 16'sd2;
    din[2] = 16'sd3;
    run_block(3, 16'hFFFE, "wrap");

    fill_rand();
    run_block(2000, 16'h0000, "clamp");

    for (int r = 0; r < 6; r++) begin
      fill_rand();
      run_block($urandom_range(1, 40),
                16'($urandom), "rand");
    end

    fill_rand();
    mem.delete();
    size    = 16'd10;
    address = 16'd200;
    enable  = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort wr", {31'h0, dmaWrite}, 32'h1);
    end
    enable = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort idle wr", {31'h0, dmaWrite}, 32'h0);
      chk("abort done", {31'h0, done}, 32'h0);
    end
    chk("abort 202", rd(202), {16'h0, din[2]});
    chk("abort 203", rd(203), 32'h1_0000);
    run_block(10, 16'd200, "restart");

    fill_rand();
    size    = 16'd10;
    address = 16'd300;
    enable  = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mid wr", {31'h0, dmaWrite}, 32'h1);
    chk("mid addr", {16'h0, dmaAddr}, 32'd305);
    #2 reset = 1'b1;
    #1 chk_zero("async rst");
    @(posedge clk); #1;
    chk_zero("held rst");
    reset = 1'b0;
    run_block(10, 16'd700, "post rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
